// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of up to 8 AXI-Stream producers onto one
// registered output stage. Each beat is tagged with its source index in tuser.
module axis_packet_arbiter #(
    parameter int C_NUM_INPUTS = 4,
    parameter int C_AXIS_WIDTH = 64,
    localparam int C_SRC_WIDTH = (C_NUM_INPUTS > 2) ? $clog2(C_NUM_INPUTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [C_NUM_INPUTS*C_AXIS_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_INPUTS-1:0]              s_axis_tlast,
    input  logic [C_NUM_INPUTS-1:0]              s_axis_tvalid,
    output logic [C_NUM_INPUTS-1:0]              s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0]              m_axis_tdata,
    output logic                                 m_axis_tlast,
    output logic [C_SRC_WIDTH-1:0]               m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [C_SRC_WIDTH-1:0]               active_src,
    output logic                                 busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [C_SRC_WIDTH-1:0]  ptr_q, ptr_d;
    logic [C_SRC_WIDTH-1:0]  gnt_q, gnt_d;
    logic [C_AXIS_WIDTH-1:0] tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic [C_SRC_WIDTH-1:0]  tuser_q, tuser_d;
    logic                    tvalid_q, tvalid_d;

    logic [C_AXIS_WIDTH-1:0] in_data_s [C_NUM_INPUTS];
    logic                    out_ready_s;
    logic                    beat_s;
    logic                    gnt_valid_s;
    logic                    gnt_last_s;
    logic [C_SRC_WIDTH-1:0]  gnt_next_s;
    logic                    arb_found_s;
    logic [C_SRC_WIDTH-1:0]  arb_idx_s;
    logic [C_SRC_WIDTH-1:0]  cand_s;
    int                      pos_s;

    // Unpack the flat tdata bus into per-input words.
    always_comb begin
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            in_data_s[i] = s_axis_tdata[i*C_AXIS_WIDTH +: C_AXIS_WIDTH];
        end
    end

    assign out_ready_s = !tvalid_q || m_axis_tready;
    assign gnt_valid_s = s_axis_tvalid[gnt_q];
    assign gnt_last_s  = s_axis_tlast[gnt_q];
    assign beat_s      = (state_q == STREAM) && gnt_valid_s && out_ready_s;
    assign gnt_next_s  = (int'(gnt_q) == C_NUM_INPUTS - 1) ? '0 : gnt_q + 1'b1;

    // Search ptr, ptr+1, ... with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        cand_s      = '0;
        pos_s       = 0;
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            pos_s = int'(ptr_q) + k;
            if (pos_s >= C_NUM_INPUTS) begin
                pos_s = pos_s - C_NUM_INPUTS;
            end else begin
                pos_s = pos_s;
            end
            cand_s = C_SRC_WIDTH'(pos_s);
            if (!arb_found_s && s_axis_tvalid[cand_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Only the granted input sees ready, and only while the output can take a beat.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == STREAM) begin
            s_axis_tready[gnt_q] = out_ready_s;
        end else begin
            s_axis_tready = '0;
        end
    end

    // Next-state: grant holds for a whole packet; output register load/drain.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        case (state_q)
            IDLE: begin
                if (arb_found_s) begin
                    gnt_d   = arb_idx_s;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (beat_s && gnt_last_s) begin
                    ptr_d   = gnt_next_s;
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (beat_s) begin
            tdata_d  = in_data_s[gnt_q];
            tlast_d  = gnt_last_s;
            tuser_d  = gnt_q;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and output register; reset discards any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign active_src    = gnt_q;
    assign busy          = (state_q == STREAM);

endmodule
